// File: rtl/decode_pkg.sv
// decode_pkg: MIPS opcode/funct encodings and immediate-extension modes shared by the decode stage.
package decode_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    typedef enum logic [1:0] {IMM_SEXT, IMM_ZEXT, IMM_LUI} imm_mode_e;

    function automatic imm_mode_e imm_mode(input logic [5:0] op);
        return (op == OP_ORI) ? IMM_ZEXT : (op == OP_LUI) ? IMM_LUI : IMM_SEXT;
    endfunction
endpackage

// File: rtl/grf_p.sv
// grf_p: register file with async active-low reset, hard-wired $0 and write-to-read bypass.
// Define GRF_WRITE_LOG_EN to print every committed write (simulation only).
module grf_p #(
    parameter  int XLEN = 32,
    parameter  int NREG = 32,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            i_rst_n,
    input  logic            i_we,
    input  logic [31:0]     i_pc,
    input  logic [AW-1:0]   i_a3,
    input  logic [XLEN-1:0] i_wd,
    input  logic [AW-1:0]   i_ra1,
    input  logic [AW-1:0]   i_ra2,
    output logic [XLEN-1:0] o_rd1,
    output logic [XLEN-1:0] o_rd2
);
    logic [XLEN-1:0] r_regs [NREG];
    logic            w_commit;

    // $0 is never written, so its storage stays at the reset value of zero
    assign w_commit = i_we && (i_a3 != '0);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else if (w_commit) begin
            r_regs[i_a3] <= i_wd;
        end
    end

    assign o_rd1 = (w_commit && i_a3 == i_ra1) ? i_wd : r_regs[i_ra1];
    assign o_rd2 = (w_commit && i_a3 == i_ra2) ? i_wd : r_regs[i_ra2];

`ifdef GRF_WRITE_LOG_EN
    always @(posedge clk) begin
        if (i_rst_n && w_commit) $display("@%h: $%d <= %h", i_pc, i_a3, i_wd);
    end
`else
    logic w_unused_pc;
    assign w_unused_pc = ^i_pc;
`endif
endmodule

// File: rtl/decode_stage_p.sv
// decode_stage_p: MIPS decode with register file, branch/jump resolution and registered D/E boundary.
// Optional write logging in the register file via GRF_WRITE_LOG_EN.
module decode_stage_p
    import decode_pkg::*;
#(
    parameter  int XLEN   = 32,
    parameter  int NREG   = 32,
    parameter  int RA_IDX = 31,
    localparam int AW     = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     f_pc,
    input  logic            d_valid,
    input  logic [31:0]     d_pc,
    input  logic [31:0]     d_instr,
    input  logic [XLEN-1:0] fw_rs,
    input  logic [XLEN-1:0] fw_rt,
    input  logic            stall,
    input  logic            flush,
    input  logic            w_we,
    input  logic [31:0]     w_pc,
    input  logic [AW-1:0]   w_a3,
    input  logic [XLEN-1:0] w_wd,
    output logic [XLEN-1:0] d_rd1,
    output logic [XLEN-1:0] d_rd2,
    output logic [31:0]     npc,
    output logic            br_taken,
    output logic            e_valid,
    output logic [31:0]     e_pc,
    output logic [31:0]     e_instr,
    output logic [XLEN-1:0] e_rs_val,
    output logic [XLEN-1:0] e_rt_val,
    output logic [XLEN-1:0] e_imm,
    output logic [AW-1:0]   e_a3,
    output logic [31:0]     e_link
);
    typedef struct packed {
        logic            valid;
        logic [31:0]     pc;
        logic [31:0]     instr;
        logic [XLEN-1:0] rs_val;
        logic [XLEN-1:0] rt_val;
        logic [XLEN-1:0] imm;
        logic [AW-1:0]   a3;
        logic [31:0]     link;
    } de_t;

    logic [5:0]  w_op, w_fn;
    logic [15:0] w_imm16;
    logic        w_is_jr, w_is_jalr, w_is_j, w_is_jal, w_is_rdst, w_is_rtdst;
    logic        w_eq, w_lez, w_br_cond, w_live, w_bubble;
    logic [31:0] w_pc4, w_br_tgt, w_j_tgt;
    imm_mode_e   w_mode;
    de_t         w_de, r_de;
    logic        w_unused_shamt;

    assign w_op           = d_instr[31:26];
    assign w_fn           = d_instr[5:0];
    assign w_imm16        = d_instr[15:0];
    assign w_unused_shamt = ^d_instr[10:6];

    grf_p #(.XLEN(XLEN), .NREG(NREG)) u_grf (
        .clk     (clk),
        .i_rst_n (reset),
        .i_we    (w_we),
        .i_pc    (w_pc),
        .i_a3    (w_a3),
        .i_wd    (w_wd),
        .i_ra1   (AW'(d_instr[25:21])),
        .i_ra2   (AW'(d_instr[20:16])),
        .o_rd1   (d_rd1),
        .o_rd2   (d_rd2)
    );

    assign w_is_jr    = (w_op == OP_RTYPE) && (w_fn == FN_JR);
    assign w_is_jalr  = (w_op == OP_RTYPE) && (w_fn == FN_JALR);
    assign w_is_j     = (w_op == OP_J);
    assign w_is_jal   = (w_op == OP_JAL);
    assign w_is_rdst  = (w_op == OP_RTYPE) && (w_fn == FN_ADDU || w_fn == FN_SUBU || w_fn == FN_JALR);
    assign w_is_rtdst = (w_op == OP_ORI) || (w_op == OP_LUI) || (w_op == OP_LW);

    // Branches resolve on the forwarded operands so a just-produced value is honoured
    assign w_eq      = (fw_rs == fw_rt);
    assign w_lez     = fw_rs[XLEN-1] || (fw_rs == '0);
    assign w_br_cond = (w_op == OP_BEQ)  ?  w_eq  :
                       (w_op == OP_BNE)  ? !w_eq  :
                       (w_op == OP_BLEZ) ?  w_lez :
                       (w_op == OP_BGTZ) ? !w_lez : 1'b0;

    assign w_live   = d_valid && !flush;
    assign w_pc4    = f_pc + 32'd4;
    assign w_br_tgt = d_pc + 32'd4 + {{14{w_imm16[15]}}, w_imm16, 2'b00};
    assign w_j_tgt  = {d_pc[31:28], d_instr[25:0], 2'b00};

    always_comb begin
        npc = !w_live                ? w_pc4    :
              w_br_cond              ? w_br_tgt :
              (w_is_j || w_is_jal)   ? w_j_tgt  :
              (w_is_jr || w_is_jalr) ? fw_rs[31:0] : w_pc4;
        br_taken = w_live && (w_br_cond || w_is_j || w_is_jal || w_is_jr || w_is_jalr);
    end

    assign w_mode = imm_mode(w_op);

    always_comb begin
        w_de        = '0;
        w_de.valid  = 1'b1;
        w_de.pc     = d_pc;
        w_de.instr  = d_instr;
        w_de.rs_val = fw_rs;
        w_de.rt_val = fw_rt;
        w_de.imm    = (w_mode == IMM_ZEXT) ? XLEN'(w_imm16) :
                      (w_mode == IMM_LUI)  ? XLEN'({w_imm16, 16'h0000}) :
                                             {{(XLEN-16){w_imm16[15]}}, w_imm16};
        w_de.a3     = (w_op == OP_SW) ? '0 :
                      w_is_rdst       ? AW'(d_instr[15:11]) :
                      w_is_jal        ? AW'(RA_IDX) :
                      w_is_rtdst      ? AW'(d_instr[20:16]) : '0;
        w_de.link   = (w_is_jal || w_is_jalr) ? d_pc + 32'd8 : 32'd0;
    end

    assign w_bubble = flush || stall || !d_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_de <= '0;
        else        r_de <= w_bubble ? '0 : w_de;
    end

    assign e_valid  = r_de.valid;
    assign e_pc     = r_de.pc;
    assign e_instr  = r_de.instr;
    assign e_rs_val = r_de.rs_val;
    assign e_rt_val = r_de.rt_val;
    assign e_imm    = r_de.imm;
    assign e_a3     = r_de.a3;
    assign e_link   = r_de.link;
endmodule

// File: tb/tb_decode_stage_p.sv
// tb_decode_stage_p: directed plus randomized checks of decode_stage_p against a behavioural model.
module tb_decode_stage_p;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [31:0]     f_pc, d_pc, d_instr, w_pc;
    logic            d_valid, stall, flush, w_we;
    logic [XLEN-1:0] fw_rs, fw_rt, w_wd;
    logic [AW-1:0]   w_a3;
    logic [XLEN-1:0] d_rd1, d_rd2, e_rs_val, e_rt_val, e_imm;
    logic [31:0]     npc, e_pc, e_instr, e_link;
    logic            br_taken, e_valid;
    logic [AW-1:0]   e_a3;

    always #5 clk = ~clk;

    decode_stage_p #(.XLEN(XLEN), .NREG(NREG), .RA_IDX(31)) dut (
        .clk(clk), .reset(reset), .f_pc(f_pc), .d_valid(d_valid), .d_pc(d_pc),
        .d_instr(d_instr), .fw_rs(fw_rs), .fw_rt(fw_rt), .stall(stall), .flush(flush),
        .w_we(w_we), .w_pc(w_pc), .w_a3(w_a3), .w_wd(w_wd), .d_rd1(d_rd1), .d_rd2(d_rd2),
        .npc(npc), .br_taken(br_taken), .e_valid(e_valid), .e_pc(e_pc), .e_instr(e_instr),
        .e_rs_val(e_rs_val), .e_rt_val(e_rt_val), .e_imm(e_imm), .e_a3(e_a3), .e_link(e_link)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] ref_rf [32];
    logic        exp_valid;
    logic [31:0] exp_pc, exp_instr, exp_rs, exp_rt, exp_imm, exp_link;
    logic [4:0]  exp_a3;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_e();
        check("e_valid", 64'(e_valid), 64'(exp_valid));
        check("e_pc", 64'(e_pc), 64'(exp_pc));
        check("e_instr", 64'(e_instr), 64'(exp_instr));
        check("e_rs_val", 64'(e_rs_val), 64'(exp_rs));
        check("e_rt_val", 64'(e_rt_val), 64'(exp_rt));
        check("e_imm", 64'(e_imm), 64'(exp_imm));
        check("e_a3", 64'(e_a3), 64'(exp_a3));
        check("e_link", 64'(e_link), 64'(exp_link));
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;
        {exp_valid, exp_pc, exp_instr, exp_rs, exp_rt, exp_imm, exp_a3, exp_link} = '0;
    endtask

    function automatic logic [31:0] ref_read(input logic [4:0] a);
        if (w_we && w_a3 != 0 && w_a3 == a) return w_wd;
        return ref_rf[a];
    endfunction

    task automatic cycle(input logic [31:0] instr, input logic [31:0] pc_d, input logic [31:0] pc_f,
                         input logic [31:0] rs_v, input logic [31:0] rt_v, input logic valid,
                         input logic stl, input logic fl, input logic we, input logic [4:0] a3,
                         input logic [31:0] wd);
        logic [5:0]  op, fn;
        logic [31:0] e_npc;
        logic        e_tk, live;
        int          simm;
        @(negedge clk);
        d_instr = instr; d_pc = pc_d; f_pc = pc_f; fw_rs = rs_v; fw_rt = rt_v;
        d_valid = valid; stall = stl; flush = fl; w_we = we; w_a3 = a3; w_wd = wd; w_pc = pc_d - 32'd12;
        #1;
        op = instr[31:26]; fn = instr[5:0]; simm = $signed(instr[15:0]);
        live = valid && !fl;
        e_tk = 1'b0; e_npc = pc_f + 32'd4;
        if (live) begin
            case (op)
                6'h04: e_tk = (rs_v == rt_v);
                6'h05: e_tk = (rs_v != rt_v);
                6'h06: e_tk = ($signed(rs_v) <= 0);
                6'h07: e_tk = ($signed(rs_v) > 0);
                default: e_tk = 1'b0;
            endcase
            if (e_tk) e_npc = pc_d + 32'd4 + 32'(simm * 4);
            else if (op == 6'h02 || op == 6'h03) begin
                e_tk = 1'b1; e_npc = {pc_d[31:28], instr[25:0], 2'b00};
            end else if (op == 6'h00 && (fn == 6'h08 || fn == 6'h09)) begin
                e_tk = 1'b1; e_npc = rs_v;
            end
        end
        check("npc", 64'(npc), 64'(e_npc));
        check("br_taken", 64'(br_taken), 64'(e_tk));
        check("d_rd1", 64'(d_rd1), 64'(ref_read(instr[25:21])));
        check("d_rd2", 64'(d_rd2), 64'(ref_read(instr[20:16])));
        if (!valid || stl || fl) begin
            {exp_valid, exp_pc, exp_instr, exp_rs, exp_rt, exp_imm, exp_a3, exp_link} = '0;
        end else begin
            exp_valid = 1'b1; exp_pc = pc_d; exp_instr = instr; exp_rs = rs_v; exp_rt = rt_v;
            exp_imm  = (op == 6'h0D) ? {16'h0, instr[15:0]} :
                       (op == 6'h0F) ? {instr[15:0], 16'h0} : 32'(simm);
            exp_a3   = (op == 6'h00 && (fn == 6'h21 || fn == 6'h23 || fn == 6'h09)) ? instr[15:11] :
                       (op == 6'h03) ? 5'd31 :
                       (op == 6'h0D || op == 6'h0F || op == 6'h23) ? instr[20:16] : 5'd0;
            exp_link = (op == 6'h03 || (op == 6'h00 && fn == 6'h09)) ? pc_d + 32'd8 : 32'd0;
        end
        @(posedge clk);
        if (we && a3 != 0) ref_rf[a3] = wd;
        #1;
        check_e();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        clear_model();
        check_e();
        @(negedge clk);
        reset = 1'b1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 13))
            0, 1:  op = 6'h00;
            2:     op = 6'h02;
            3:     op = 6'h03;
            4:     op = 6'h04;
            5:     op = 6'h05;
            6:     op = 6'h06;
            7:     op = 6'h07;
            8:     op = 6'h0D;
            9:     op = 6'h0F;
            10:    op = 6'h23;
            11:    op = 6'h2B;
            12:    op = 6'h3F;
            default: op = 6'h00;
        endcase
        case ($urandom_range(0, 4))
            0: fn = 6'h21;
            1: fn = 6'h23;
            2: fn = 6'h08;
            3: fn = 6'h09;
            default: fn = r[5:0];
        endcase
        r[25:21] = 5'($urandom_range(0, 7));
        r[20:16] = 5'($urandom_range(0, 7));
        return (op == 6'h00) ? {op, r[25:6], fn} : {op, r[25:0]};
    endfunction

    initial begin
        logic [31:0] ins, rs_v, rt_v;
        {f_pc, d_pc, d_instr, w_pc, fw_rs, fw_rt, w_wd} = '0;
        {d_valid, stall, flush, w_we} = '0;
        w_a3 = '0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        check_e();
        @(negedge clk);
        reset = 1'b1;

        cycle({6'h00, 5'd5, 5'd6, 5'd7, 5'd0, 6'h21}, 32'h3000, 32'h3004, 32'd1, 32'd2, 1, 0, 0, 1, 5'd5, 32'hDEAD_BEEF);
        cycle({6'h00, 5'd0, 5'd5, 5'd7, 5'd0, 6'h23}, 32'h3004, 32'h3008, 32'd1, 32'd2, 1, 0, 0, 1, 5'd0, 32'hFFFF_FFFF);
        cycle({6'h04, 5'd1, 5'd2, 16'hFFFF}, 32'h3004, 32'h5000, 32'd7, 32'd7, 1, 0, 0, 0, 5'd0, 32'd0);
        cycle({6'h05, 5'd1, 5'd2, 16'hFFFF}, 32'h3004, 32'h5000, 32'd7, 32'd7, 1, 0, 0, 0, 5'd0, 32'd0);
        cycle({6'h03, 26'h0000C01}, 32'h3000, 32'h5000, 32'd0, 32'd0, 1, 0, 0, 0, 5'd0, 32'd0);
        cycle({6'h07, 5'd1, 5'd0, 16'h0010}, 32'h3000, 32'h5000, 32'h8000_0000, 32'd0, 1, 0, 0, 0, 5'd0, 32'd0);
        cycle({6'h06, 5'd1, 5'd0, 16'h0010}, 32'h3000, 32'h5000, 32'h8000_0000, 32'd0, 1, 0, 0, 0, 5'd0, 32'd0);
        cycle({6'h0F, 5'd0, 5'd3, 16'h8001}, 32'h3000, 32'h5000, 32'd0, 32'd0, 1, 0, 0, 0, 5'd0, 32'd0);
        cycle({6'h0D, 5'd2, 5'd3, 16'h8001}, 32'h3000, 32'h5000, 32'd0, 32'd0, 1, 0, 0, 0, 5'd0, 32'd0);
        cycle({6'h00, 5'd5, 5'd6, 5'd7, 5'd0, 6'h21}, 32'h3010, 32'h5000, 32'd3, 32'd4, 1, 1, 0, 0, 5'd0, 32'd0);
        cycle({6'h00, 5'd5, 5'd6, 5'd7, 5'd0, 6'h21}, 32'h3010, 32'h5000, 32'd3, 32'd4, 1, 1, 1, 0, 5'd0, 32'd0);
        cycle({6'h00, 5'd5, 5'd6, 5'd7, 5'd0, 6'h21}, 32'h3010, 32'h5000, 32'd3, 32'd4, 1, 0, 0, 0, 5'd0, 32'd0);
        cycle({6'h00, 5'd9, 5'd0, 5'd4, 5'd0, 6'h09}, 32'hFFFF_FFF8, 32'h5000, 32'h1234, 32'd0, 1, 0, 0, 0, 5'd0, 32'd0);
        do_reset();
        cycle({6'h00, 5'd5, 5'd5, 5'd7, 5'd0, 6'h21}, 32'h3000, 32'h3004, 32'd0, 32'd0, 1, 0, 0, 0, 5'd0, 32'd0);

        for (int n = 0; n < 400; n++) begin
            ins  = rand_instr();
            rs_v = ($urandom_range(0, 3) == 0) ? 32'd0 :
                   ($urandom_range(0, 3) == 0) ? 32'h8000_0000 | $urandom : $urandom;
            rt_v = ($urandom_range(0, 2) == 0) ? rs_v : $urandom;
            if (n == 200) do_reset();
            cycle(ins, $urandom, $urandom, rs_v, rt_v, $urandom_range(0, 7) != 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 2) == 0) ? ins[25:21] : 5'($urandom_range(0, 7)), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
